// File: rtl/ps2_mouse_device.sv
// PS/2 mouse device-side emulator: clocks out 3-byte movement packets and, when
// PS2_MOUSE_DEV_CMD_RX_EN is defined, receives/acks host commands and answers them.
module ps2_mouse_device #(
  parameter int CLK_HALF   = 2000,
  parameter int GAP_CYCLES = 4000,
  parameter int RTS_MIN    = 5000
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic       send,
  input  logic       l_btn,
  input  logic       m_btn,
  input  logic       r_btn,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  output logic       busy,
  output logic       enabled,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte
);

  localparam int MAX_AB = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
  localparam int MAXV   = (MAX_AB > RTS_MIN) ? MAX_AB : RTS_MIN;
  localparam int CW     = $clog2(MAXV + 1);

  typedef enum logic [2:0] {IDLE, GAP, TX, RTS_WAIT, RX, RX_ACK} state_t;

  state_t        state;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_s, dat_s;
  logic          clk_oe, dat_oe;
  logic [CW-1:0] cnt;
  logic          low_half;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;
  logic [7:0]    pkt0, pkt1, pkt2;
  logic [1:0]    pkt_idx;
  logic [7:0]    tx_byte;

`ifdef PS2_MOUSE_DEV_CMD_RX_EN
  logic          src_rsp;
  logic [7:0]    rsp_q [0:2];
  logic [1:0]    rsp_cnt;
  logic [8:0]    rx_sr;
  logic          rx_good;
  logic [7:0]    rx_data;
`endif

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;
  assign clk_s   = clk_sync[1];
  assign dat_s   = dat_sync[1];

  // Byte to serialize next: pending response bytes take precedence over the packet.
  always_comb begin
    case (pkt_idx)
      2'd1:    tx_byte = pkt1;
      2'd2:    tx_byte = pkt2;
      default: tx_byte = pkt0;
    endcase
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
    if (src_rsp) tx_byte = rsp_q[0];
`endif
  end

`ifdef PS2_MOUSE_DEV_CMD_RX_EN
  // Stop bit is the live sample; parity and data were shifted in before it.
  assign rx_data = rx_sr[7:0];
  assign rx_good = dat_s && (^rx_sr);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      low_half  <= 1'b0;
      bit_idx   <= '0;
      frame     <= '1;
      clk_oe    <= 1'b0;
      dat_oe    <= 1'b0;
      busy      <= 1'b0;
      enabled   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= 8'h00;
      pkt0      <= 8'h00;
      pkt1      <= 8'h00;
      pkt2      <= 8'h00;
      pkt_idx   <= 2'd0;
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
      src_rsp   <= 1'b0;
      rsp_q[0]  <= 8'h00;
      rsp_q[1]  <= 8'h00;
      rsp_q[2]  <= 8'h00;
      rsp_cnt   <= 2'd0;
      rx_sr     <= '0;
`endif
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      dat_sync  <= {dat_sync[0], PS2_DAT};
      cmd_valid <= 1'b0;
`ifndef PS2_MOUSE_DEV_CMD_RX_EN
      enabled   <= 1'b1;
`endif

      if (send && !busy) begin
        busy <= 1'b1;
        pkt0 <= {2'b00, dy[8], dx[8], 1'b1, m_btn, r_btn, l_btn};
        pkt1 <= dx[7:0];
        pkt2 <= dy[7:0];
      end

      case (state)
        IDLE: begin
          cnt      <= '0;
          low_half <= 1'b0;
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
          if (!clk_s) begin
            state <= RTS_WAIT;
          end else if (rsp_cnt != 2'd0) begin
            src_rsp <= 1'b1;
            state   <= GAP;
          end else if (busy && enabled) begin
            src_rsp <= 1'b0;
            state   <= GAP;
          end
`else
          if (busy && enabled) state <= GAP;
`endif
        end

        GAP: begin
          if (clk_s && dat_s) begin
            if (cnt == CW'(GAP_CYCLES - 1)) begin
              frame    <= {1'b1, ~^tx_byte, tx_byte};
              bit_idx  <= '0;
              dat_oe   <= 1'b1;
              low_half <= 1'b0;
              cnt      <= '0;
              state    <= TX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
            if (!clk_s) state <= IDLE;
`endif
          end
        end

        // The first cycles of each released half are skipped because the
        // synchronizer still shows our own low drive.
        TX: begin
          cnt <= cnt + 1'b1;
          if (!low_half) begin
            if (cnt >= CW'(3) && !clk_s) begin
              clk_oe <= 1'b0;
              dat_oe <= 1'b0;
              state  <= IDLE;
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
              if (!src_rsp) pkt_idx <= 2'd0;
`else
              pkt_idx <= 2'd0;
`endif
            end else if (cnt == CW'(CLK_HALF - 1)) begin
              clk_oe   <= 1'b1;
              low_half <= 1'b1;
              cnt      <= '0;
            end
          end else if (cnt == CW'(CLK_HALF - 1)) begin
            clk_oe   <= 1'b0;
            low_half <= 1'b0;
            cnt      <= '0;
            if (bit_idx == 4'd10) begin
              dat_oe <= 1'b0;
              state  <= IDLE;
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
              if (src_rsp) begin
                rsp_q[0] <= rsp_q[1];
                rsp_q[1] <= rsp_q[2];
                rsp_cnt  <= rsp_cnt - 1'b1;
              end else if (pkt_idx == 2'd2) begin
                busy    <= 1'b0;
                pkt_idx <= 2'd0;
              end else begin
                pkt_idx <= pkt_idx + 1'b1;
              end
`else
              if (pkt_idx == 2'd2) begin
                busy    <= 1'b0;
                pkt_idx <= 2'd0;
              end else begin
                pkt_idx <= pkt_idx + 1'b1;
              end
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              dat_oe  <= ~frame[0];
              frame   <= {1'b1, frame[9:1]};
            end
          end
        end

`ifdef PS2_MOUSE_DEV_CMD_RX_EN
        RTS_WAIT: begin
          if (!clk_s) begin
            if (cnt != CW'(RTS_MIN)) cnt <= cnt + 1'b1;
          end else begin
            cnt      <= '0;
            low_half <= 1'b0;
            bit_idx  <= '0;
            state    <= (cnt == CW'(RTS_MIN) && !dat_s) ? RX : IDLE;
          end
        end

        // Bit 0 is the host's start bit, 1..8 data, 9 parity, 10 stop.
        RX: begin
          cnt <= cnt + 1'b1;
          if (!low_half) begin
            if (cnt >= CW'(3) && !clk_s) begin
              clk_oe <= 1'b0;
              state  <= IDLE;
            end else if (cnt == CW'(CLK_HALF - 1)) begin
              clk_oe   <= 1'b1;
              low_half <= 1'b1;
              cnt      <= '0;
            end
          end else begin
            if (cnt == CW'(CLK_HALF / 2)) begin
              if (bit_idx == 4'd10) begin
                rsp_cnt <= 2'd1;
                if (rx_good) begin
                  cmd_valid <= 1'b1;
                  cmd_byte  <= rx_data;
                  rsp_q[0]  <= 8'hFA;
                  case (rx_data)
                    8'hFF: begin
                      rsp_q[1] <= 8'hAA;
                      rsp_q[2] <= 8'h00;
                      rsp_cnt  <= 2'd3;
                      enabled  <= 1'b0;
                    end
                    8'hF4: enabled <= 1'b1;
                    8'hF5: enabled <= 1'b0;
                    8'hF2: begin
                      rsp_q[1] <= 8'h00;
                      rsp_cnt  <= 2'd2;
                    end
                    default: ;
                  endcase
                end else begin
                  rsp_q[0] <= 8'hFE;
                end
              end else begin
                rx_sr <= {dat_s, rx_sr[8:1]};
              end
            end
            if (cnt == CW'(CLK_HALF - 1)) begin
              clk_oe   <= 1'b0;
              low_half <= 1'b0;
              cnt      <= '0;
              if (bit_idx == 4'd10) begin
                dat_oe <= 1'b1;
                state  <= RX_ACK;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
        end

        RX_ACK: begin
          cnt <= cnt + 1'b1;
          if (!low_half) begin
            if (cnt == CW'(CLK_HALF - 1)) begin
              clk_oe   <= 1'b1;
              low_half <= 1'b1;
              cnt      <= '0;
            end
          end else if (cnt == CW'(CLK_HALF - 1)) begin
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
            low_half <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end
        end
`endif

        default: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Directed bench for ps2_mouse_device acting as a PS/2 host with pull-ups on both lines;
// the command section is compiled only with PS2_MOUSE_DEV_CMD_RX_EN.
module tb_ps2_mouse_device;

  localparam int CLK_HALF   = 20;
  localparam int GAP_CYCLES = 40;
  localparam int RTS_MIN    = 50;
  localparam int LIMIT      = 2000;
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
  localparam logic EN_AFTER_RESET = 1'b0;
`else
  localparam logic EN_AFTER_RESET = 1'b1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  wire        ps2_clk, ps2_dat;
  logic       host_clk_low = 1'b0, host_dat_low = 1'b0;
  logic       send, l_btn, m_btn, r_btn;
  logic [8:0] dx, dy;
  logic       busy, enabled, cmd_valid;
  logic [7:0] cmd_byte;

  int n_vec = 0, n_err = 0, cyc = 0, valid_cnt = 0, last_stop = 0;
  bit dead = 1'b0;

  always #5 clock = ~clock;

  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  ps2_mouse_device #(
    .CLK_HALF(CLK_HALF), .GAP_CYCLES(GAP_CYCLES), .RTS_MIN(RTS_MIN)
  ) dut (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .send(send), .l_btn(l_btn), .m_btn(m_btn), .r_btn(r_btn), .dx(dx), .dy(dy),
    .busy(busy), .enabled(enabled), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Waits for PS2_CLK to reach lvl; once a wait has expired every later wait returns at once.
  task automatic wait_clk(input logic lvl, input string tag);
    logic prev;
    bit   hit;
    hit  = 1'b0;
    prev = ps2_clk;
    for (int i = 0; i < LIMIT && !hit && !dead; i++) begin
      @(negedge clock);
      if (prev !== lvl && ps2_clk === lvl) hit = 1'b1;
      prev = ps2_clk;
    end
    if (!dead) begin
      assert (hit) else begin
        n_vec++;
        n_err++;
        dead = 1'b1;
        $error("[TB] FAIL %s: observed no PS2_CLK edge, expected one within %0d cycles", tag, LIMIT);
      end
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic expect_byte(input string tag, input logic [7:0] b, input bit check_gap);
    logic [10:0] fr;
    int t0;
    fr = '0;
    t0 = 0;
    for (int i = 0; i < 11; i++) begin
      wait_clk(1'b0, {tag, " edge"});
      fr[i] = ps2_dat;
      if (i == 0) t0 = cyc;
    end
    check_output(tag, 32'(fr), 32'(frame_of(b)));
    if (check_gap)
      check_output({tag, " gap"}, 32'(t0 - last_stop >= GAP_CYCLES + 2 * CLK_HALF), 32'd1);
    last_stop = cyc;
  endtask

  task automatic pulse_send(input logic l, input logic m, input logic r,
                            input logic [8:0] x, input logic [8:0] y);
    @(negedge clock);
    l_btn = l; m_btn = m; r_btn = r; dx = x; dy = y; send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

`ifdef PS2_MOUSE_DEV_CMD_RX_EN
  // Host-to-device transfer; data changes right after each device rising edge.
  task automatic host_send(input logic [7:0] b, input logic flip_par, output logic ack_low);
    logic [9:0] bits;
    bits = {1'b1, (~^b) ^ flip_par, b};
    @(negedge clock);
    host_clk_low = 1'b1;
    cycles(RTS_MIN + 10);
    host_dat_low = 1'b1;
    cycles(5);
    host_clk_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_clk(1'b0, "host bit fall");
      wait_clk(1'b1, "host bit rise");
      host_dat_low = ~bits[i];
    end
    wait_clk(1'b0, "stop fall");
    wait_clk(1'b1, "stop rise");
    wait_clk(1'b0, "ack fall");
    ack_low = (ps2_dat === 1'b0);
    wait_clk(1'b1, "ack rise");
  endtask
`endif

  initial begin
`ifdef PS2_MOUSE_DEV_CMD_RX_EN
    logic ack;
    int   vc;
`endif
    reset = 1'b1; send = 1'b0; l_btn = 1'b0; m_btn = 1'b0; r_btn = 1'b0;
    dx = '0; dy = '0;
    cycles(3);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset enabled", 32'(enabled), 32'd0);
    check_output("reset cmd_valid", 32'(cmd_valid), 32'd0);
    check_output("reset cmd_byte", 32'(cmd_byte), 32'h00);
    check_output("reset PS2_CLK", 32'(ps2_clk), 32'd1);
    check_output("reset PS2_DAT", 32'(ps2_dat), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    cycles(2);
    check_output("enabled after reset", 32'(enabled), 32'(EN_AFTER_RESET));

`ifdef PS2_MOUSE_DEV_CMD_RX_EN
    vc = valid_cnt;
    host_send(8'hF4, 1'b0, ack);
    check_output("F4 ack", 32'(ack), 32'd1);
    check_output("F4 cmd_valid", 32'(valid_cnt - vc), 32'd1);
    check_output("F4 cmd_byte", 32'(cmd_byte), 32'hF4);
    expect_byte("F4 reply", 8'hFA, 1'b0);
    check_output("F4 enabled", 32'(enabled), 32'd1);
`endif

    // Packet l=1 dx=+5 dy=-3, plus a second send while busy that must be ignored.
    pulse_send(1'b1, 1'b0, 1'b0, 9'd5, 9'h1FD);
    check_output("busy after send", 32'(busy), 32'd1);
    pulse_send(1'b0, 1'b1, 1'b1, 9'd7, 9'd7);
    expect_byte("pkt1 byte0", 8'h29, 1'b0);
    expect_byte("pkt1 byte1", 8'h05, 1'b1);
    expect_byte("pkt1 byte2", 8'hFD, 1'b1);
    check_output("busy during stop", 32'(busy), 32'd1);
    cycles(CLK_HALF + 2);
    check_output("busy after pkt1", 32'(busy), 32'd0);
    check_output("cmd_valid quiet", 32'(cmd_valid), 32'd0);
`ifndef PS2_MOUSE_DEV_CMD_RX_EN
    check_output("cmd_byte tied", 32'(cmd_byte), 32'h00);
`endif

    // Packet m=1 r=1 dx=-32 dy=+2, inhibited by the host during bit 4 of byte1.
    cycles(5);
    pulse_send(1'b0, 1'b1, 1'b1, 9'h1E0, 9'd2);
    expect_byte("pkt2 byte0", 8'h1E, 1'b0);
    for (int i = 0; i < 5; i++) wait_clk(1'b0, "pkt2 partial fall");
    wait_clk(1'b1, "pkt2 bit4 rise");
    check_output("bit4 driven low", 32'(ps2_dat), 32'd0);
    cycles(5);
    host_clk_low = 1'b1;
    cycles(4);
    check_output("DAT released on inhibit", 32'(ps2_dat), 32'd1);
    cycles(30);
    host_clk_low = 1'b0;
    cycles(3);
    check_output("CLK released on inhibit", 32'(ps2_clk), 32'd1);
    expect_byte("pkt2 retry byte0", 8'h1E, 1'b0);
    expect_byte("pkt2 retry byte1", 8'hE0, 1'b1);
    expect_byte("pkt2 retry byte2", 8'h02, 1'b1);
    cycles(CLK_HALF + 2);
    check_output("busy after pkt2", 32'(busy), 32'd0);

`ifdef PS2_MOUSE_DEV_CMD_RX_EN
    cycles(5);
    vc = valid_cnt;
    host_send(8'hF4, 1'b1, ack);
    check_output("bad parity ack", 32'(ack), 32'd1);
    check_output("bad parity no valid", 32'(valid_cnt - vc), 32'd0);
    check_output("bad parity cmd_byte", 32'(cmd_byte), 32'hF4);
    expect_byte("bad parity reply", 8'hFE, 1'b0);
    check_output("bad parity enabled", 32'(enabled), 32'd1);
    cycles(5);
    host_send(8'hFF, 1'b0, ack);
    check_output("FF cmd_byte", 32'(cmd_byte), 32'hFF);
    expect_byte("FF reply0", 8'hFA, 1'b0);
    expect_byte("FF reply1", 8'hAA, 1'b1);
    expect_byte("FF reply2", 8'h00, 1'b1);
    check_output("FF enabled", 32'(enabled), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
